// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_queue
// Brief    : Instruction fetch unit with direct-mapped I-cache, 2-bit BHT
//            branch predictor and a valid/ready decoupling instruction queue.
// Revision : 1.0 - initial release
// ============================================================================
module ifetch_queue #(
  parameter int LINE_NUM   = 16,
  parameter int LINE_WORDS = 16,
  parameter int BHT_SIZE   = 64,
  parameter int QDEPTH     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rdy,
  input  logic                     rollback,
  input  logic [31:0]              rollback_pc,
  output logic                     mem_en,
  output logic [31:0]              mem_pc,
  input  logic                     mem_done,
  input  logic [LINE_WORDS*32-1:0] mem_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic [31:0]              out_pc,
  output logic                     out_pre_j,
  input  logic                     bp_upd,
  input  logic [31:0]              bp_upd_pc,
  input  logic                     bp_upd_taken
);

  localparam int c_OFF  = $clog2(LINE_WORDS) + 2;
  localparam int c_IDXW = $clog2(LINE_NUM);
  localparam int c_TAGW = 32 - c_OFF - c_IDXW;
  localparam int c_WSW  = c_OFF - 2;
  localparam int c_BHTW = $clog2(BHT_SIZE);
  localparam int c_QW   = $clog2(QDEPTH);
  localparam logic [6:0]    c_OP_JAL = 7'b1101111;
  localparam logic [6:0]    c_OP_BR  = 7'b1100011;
  localparam logic [c_QW:0] c_QFULL  = (c_QW+1)'(QDEPTH);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_FETCH = 1'b1} state_t;

  // Architectural state
  logic [31:0]       r_pc;
  logic [LINE_NUM-1:0] r_valid;
  logic [c_TAGW-1:0] r_tag  [LINE_NUM];
  logic [31:0]       r_data [LINE_NUM][LINE_WORDS];
  logic [1:0]        r_bht  [BHT_SIZE];
  logic [31:0]       r_q_inst [QDEPTH];
  logic [31:0]       r_q_pc   [QDEPTH];
  logic [QDEPTH-1:0] r_q_pj;
  logic [c_QW-1:0]   r_rd_ptr;
  logic [c_QW-1:0]   r_wr_ptr;
  logic [c_QW:0]     r_count;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_mem_pc;

  // Lookup / prediction wires
  logic [c_IDXW-1:0] w_idx;
  logic [c_TAGW-1:0] w_tag;
  logic [c_WSW-1:0]  w_word;
  logic              w_hit;
  logic [31:0]       w_inst;
  logic [c_BHTW-1:0] w_bht_idx;
  logic              w_br_taken;
  logic [31:0]       w_jimm;
  logic [31:0]       w_bimm;
  logic [31:0]       w_next;
  logic              w_pre_j;
  logic              w_pop;
  logic              w_push;
  logic              w_fill_we;
  logic [c_IDXW-1:0] w_mem_idx;
  logic [c_BHTW-1:0] w_upd_idx;
  logic              w_unused_bits;

  assign w_idx      = r_pc[c_OFF +: c_IDXW];
  assign w_tag      = r_pc[31 -: c_TAGW];
  assign w_word     = r_pc[2 +: c_WSW];
  assign w_hit      = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
  assign w_inst     = r_data[w_idx][w_word];
  assign w_bht_idx  = r_pc[2 +: c_BHTW];
  assign w_br_taken = r_bht[w_bht_idx][1];
  assign w_jimm     = {{12{w_inst[31]}}, w_inst[19:12], w_inst[20], w_inst[30:21], 1'b0};
  assign w_bimm     = {{20{w_inst[31]}}, w_inst[7], w_inst[30:25], w_inst[11:8], 1'b0};
  assign w_upd_idx  = bp_upd_pc[2 +: c_BHTW];
  assign w_mem_idx  = r_mem_pc[c_OFF +: c_IDXW];
  assign w_unused_bits = ^{bp_upd_pc[31:c_BHTW+2], bp_upd_pc[1:0]};

  // Handshake: a pop frees a slot for a same-cycle push; rollback blocks the push
  assign w_pop     = rdy && (r_count != '0) && out_ready;
  assign w_push    = rdy && w_hit && !rollback && ((r_count != c_QFULL) || w_pop);
  assign w_fill_we = rdy && (r_state == S_FETCH) && mem_done;

  assign out_valid = (r_count != '0);
  assign out_inst  = r_q_inst[r_rd_ptr];
  assign out_pc    = r_q_pc[r_rd_ptr];
  assign out_pre_j = r_q_pj[r_rd_ptr];
  assign mem_pc    = r_mem_pc;

  // Static/dynamic next-PC prediction on the word currently hitting
  always_comb begin
    w_next  = r_pc + 32'd4;
    w_pre_j = 1'b0;
    if (w_inst[6:0] == c_OP_JAL) begin
      w_next  = r_pc + w_jimm;
      w_pre_j = 1'b1;
    end else if ((w_inst[6:0] == c_OP_BR) && w_br_taken) begin
      w_next  = r_pc + w_bimm;
      w_pre_j = 1'b1;
    end
  end

  // Fetch PC: redirect wins, otherwise advance on every enqueue
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= '0;
    end else if (rdy) begin
      if (rollback)    r_pc <= rollback_pc;
      else if (w_push) r_pc <= w_next;
    end
  end

  // Circular instruction queue; rollback flushes it and discards any pop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      r_q_pj   <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        r_q_inst[i] <= '0;
        r_q_pc[i]   <= '0;
      end
    end else if (rdy) begin
      if (rollback) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_count  <= '0;
      end else begin
        if (w_push) begin
          r_q_inst[r_wr_ptr] <= w_inst;
          r_q_pc[r_wr_ptr]   <= r_pc;
          r_q_pj[r_wr_ptr]   <= w_pre_j;
          r_wr_ptr           <= r_wr_ptr + 1'b1;
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
        if (w_push && !w_pop)      r_count <= r_count + 1'b1;
        else if (w_pop && !w_push) r_count <= r_count - 1'b1;
      end
    end
  end

  // Line valid bits; set only when a refill completes
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_valid <= '0;
    else if (w_fill_we) r_valid[w_mem_idx] <= 1'b1;
  end

  // Tag and data arrays need no reset: valid bits qualify them
  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_tag[w_mem_idx] <= r_mem_pc[31 -: c_TAGW];
      for (int k = 0; k < LINE_WORDS; k++) r_data[w_mem_idx][k] <= mem_data[k*32 +: 32];
    end
  end

  // Refill FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      r_state <= S_IDLE;
    else if (rdy) r_state <= w_state_nxt;
  end

  // Refill FSM next state; a redirecting PC is not requested until it is current
  always_comb begin
    w_state_nxt = r_state;
    mem_en      = 1'b0;
    case (r_state)
      S_IDLE:  if (!w_hit && !rollback) w_state_nxt = S_FETCH;
      S_FETCH: begin
        mem_en = 1'b1;
        if (mem_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Line-aligned refill address, captured when a request is launched
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_pc <= '0;
    end else if (rdy && (r_state == S_IDLE) && (w_state_nxt == S_FETCH)) begin
      r_mem_pc <= {r_pc[31:c_OFF], {c_OFF{1'b0}}};
    end
  end

  // 2-bit saturating counter training from commit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_SIZE; i++) r_bht[i] <= 2'b01;
    end else if (rdy && bp_upd) begin
      if (bp_upd_taken) begin
        if (r_bht[w_upd_idx] != 2'b11) r_bht[w_upd_idx] <= r_bht[w_upd_idx] + 2'd1;
      end else begin
        if (r_bht[w_upd_idx] != 2'b00) r_bht[w_upd_idx] <= r_bht[w_upd_idx] - 2'd1;
      end
    end
  end

endmodule
`default_nettype wire
